cap_wrsched: RTL and testbench

Capture write scheduler: sequences the frame-buffer write path of the camera capture block. Arms on `CAP_ON`, starts each frame on the VSYNC rising edge at the programmed `CAP_ADDR`, and issues fixed-length write bursts to the memory write master whenever the pixel FIFO holds a full burst. It tracks outstanding bursts, ends the frame after a fixed burst count, and reports frame completion or abort to the capture register block.

---
 rtl/cap_wrsched_if.sv | 19 +
 rtl/cap_wrsched.sv | 165 ++++++++++++++++
 tb/tb_cap_wrsched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cap_wrsched_if.sv
// Burst request/response channel between the capture write scheduler and the
// memory write master.
interface cap_wrsched_if;
  logic        BURST_REQ;
  logic [31:0] BURST_ADDR;
  logic [7:0]  BURST_LEN;
  logic        BURST_ACK;
  logic        BURST_DONE;

  modport master (
    output BURST_REQ, BURST_ADDR, BURST_LEN,
    input  BURST_ACK, BURST_DONE
  );

  modport slave (
    input  BURST_REQ, BURST_ADDR, BURST_LEN,
    output BURST_ACK, BURST_DONE
  );
endinterface

// File: rtl/cap_wrsched.sv
// Capture write scheduler: starts a frame on VSYNC, issues fixed-length write
// bursts whenever the pixel FIFO holds a full burst, and reports frame end/abort.
module cap_wrsched #(
  parameter int BURST_BEATS  = 16,
  parameter int BEAT_BYTES   = 8,
  parameter int FRAME_BURSTS = 4800,
  parameter int MAX_OUTST    = 4
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          CAP_ON,
  input  logic [28:0]   CAP_ADDR,
  input  logic          VSYNC,
  input  logic [9:0]    FIFO_CNT,
  cap_wrsched_if.master wr,
  output logic          FIFO_CLR,
  output logic          FRAME_DONE,
  output logic          FRAME_ABORT,
  output logic          BUSY
);
  localparam int BURST_BYTES = BURST_BEATS * BEAT_BYTES;
  localparam int CNT_W       = $clog2(FRAME_BURSTS + 1);
  localparam int OUT_W       = $clog2(MAX_OUTST + 1);

  localparam logic [28:0]      STEP      = 29'(BURST_BYTES);
  localparam logic [28:0]      BASE_MASK = ~(STEP - 29'd1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BURSTS);
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTST);
  localparam logic [10:0]      BEATS_THR = 11'(BURST_BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_WAIT_DATA,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t           state_reg;
  logic             vs_meta_reg, vs_sync_reg, vs_prev_reg;
  logic [28:0]      addr_reg;
  logic [CNT_W-1:0] burst_cnt_reg;
  logic [CNT_W-1:0] burst_cnt_next;
  logic [OUT_W-1:0] outst_reg;
  logic             abort_pend_reg;
  logic             burst_req_reg;
  logic             fifo_clr_reg, frame_done_reg, frame_abort_reg, busy_reg;
  logic             vs_rise, ack_hs, fifo_ok;

  assign vs_rise        = vs_sync_reg & ~vs_prev_reg;
  assign ack_hs         = burst_req_reg & wr.BURST_ACK;
  assign fifo_ok        = {1'b0, FIFO_CNT} >= BEATS_THR;
  assign burst_cnt_next = burst_cnt_reg + 1'b1;

  assign wr.BURST_REQ  = burst_req_reg;
  assign wr.BURST_ADDR = {3'b000, addr_reg};
  assign wr.BURST_LEN  = 8'(BURST_BEATS - 1);
  assign FIFO_CLR      = fifo_clr_reg;
  assign FRAME_DONE    = frame_done_reg;
  assign FRAME_ABORT   = frame_abort_reg;
  assign BUSY          = busy_reg;

  // VSYNC is asynchronous to ACLK: two flops to settle, one more for the edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vs_meta_reg <= 1'b0;
      vs_sync_reg <= 1'b0;
      vs_prev_reg <= 1'b0;
    end else begin
      vs_meta_reg <= VSYNC;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_sync_reg;
    end
  end

  // An ACK and a DONE in the same cycle cancel; a stray DONE at zero is dropped.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      outst_reg <= '0;
    end else if (ack_hs && !wr.BURST_DONE) begin
      outst_reg <= outst_reg + 1'b1;
    end else if (!ack_hs && wr.BURST_DONE && outst_reg != '0) begin
      outst_reg <= outst_reg - 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg       <= S_IDLE;
      addr_reg        <= '0;
      burst_cnt_reg   <= '0;
      abort_pend_reg  <= 1'b0;
      burst_req_reg   <= 1'b0;
      fifo_clr_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      fifo_clr_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (CAP_ON) begin
            state_reg <= S_WAIT_VS;
            busy_reg  <= 1'b1;
          end
        end
        S_WAIT_VS: begin
          if (!CAP_ON) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else if (vs_rise) begin
            addr_reg      <= CAP_ADDR & BASE_MASK;
            burst_cnt_reg <= '0;
            fifo_clr_reg  <= 1'b1;
            state_reg     <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (vs_rise) begin
            abort_pend_reg <= 1'b1;
            state_reg      <= S_DRAIN;
          end else if (fifo_ok && outst_reg < OUT_MAX) begin
            burst_req_reg <= 1'b1;
            state_reg     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A posted request is never withdrawn; an abort waits for the ACK.
          if (vs_rise) begin
            abort_pend_reg <= 1'b1;
          end
          if (ack_hs) begin
            burst_req_reg <= 1'b0;
            addr_reg      <= addr_reg + STEP;
            burst_cnt_reg <= burst_cnt_next;
            if (burst_cnt_next == LAST_CNT || abort_pend_reg || vs_rise) begin
              state_reg <= S_DRAIN;
            end else begin
              state_reg <= S_WAIT_DATA;
            end
          end
        end
        S_DRAIN: begin
          if (outst_reg == '0) begin
            frame_done_reg  <= ~abort_pend_reg;
            frame_abort_reg <= abort_pend_reg;
            abort_pend_reg  <= 1'b0;
            if (CAP_ON) begin
              state_reg <= S_WAIT_VS;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cap_wrsched.sv
// Bench for cap_wrsched: a write-master model answers bursts while a monitor
// logs transactions and tracks the outstanding-burst count.
module tb_cap_wrsched;
  localparam int BB    = 16;
  localparam int BYTES = 8;
  localparam int FB    = 6;
  localparam int MO    = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN, CAP_ON, VSYNC;
  logic [28:0] CAP_ADDR;
  logic [9:0]  FIFO_CNT;
  logic        FIFO_CLR, FRAME_DONE, FRAME_ABORT, BUSY;

  cap_wrsched_if bif();

  cap_wrsched #(
    .BURST_BEATS (BB),
    .BEAT_BYTES  (BYTES),
    .FRAME_BURSTS(FB),
    .MAX_OUTST   (MO)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .CAP_ON     (CAP_ON),
    .CAP_ADDR   (CAP_ADDR),
    .VSYNC      (VSYNC),
    .FIFO_CNT   (FIFO_CNT),
    .wr         (bif),
    .FIFO_CLR   (FIFO_CLR),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ABORT(FRAME_ABORT),
    .BUSY       (BUSY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0, n_err = 0;
  int n_done = 0, n_abort = 0, n_clr = 0, n_dn = 0, n_req_cycles = 0, n_sim = 0;
  int dones_at_end = 0, outst_model = 0, run_len = 0;
  logic [31:0] addr_log[$];
  int          req_len_log[$];
  int          dones_at_ack[$];
  bit          req_prev_m = 0, hs_prev_m = 0;
  logic [31:0] addr_prev = '0;
  logic [9:0]  fifo_prev = '0;

  // write-master model controls
  int ack_delay = 0, done_delay = 3;
  bit ack_rand = 0, done_rand = 0, hold_done = 0, spur_done = 0, fifo_rand = 0;

  function automatic void check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_log();
    addr_log.delete();
    req_len_log.delete();
    dones_at_ack.delete();
    n_done = 0; n_abort = 0; n_clr = 0; n_dn = 0; n_req_cycles = 0; n_sim = 0;
    dones_at_end = 0;
  endtask

  task automatic pulse_vsync();
    VSYNC = 1'b1;
    repeat (4) tick();
    VSYNC = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_end(input string nm, input int budget);
    int start;
    start = n_done + n_abort;
    for (int i = 0; i < budget && (n_done + n_abort) == start; i++) tick();
    check({nm, "_frame_end_seen"}, longint'((n_done + n_abort) != start), 1);
  endtask

  task automatic wait_req(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge ACLK);
      seen = bif.BURST_REQ;
    end
    check({nm, "_req_seen"}, longint'(seen), 1);
  endtask

  // Write master: ACK after a per-request wait, DONE a set number of cycles after ACK.
  initial begin : master
    int due_q[$];
    int now, req_age, cur_ack;
    bit req_s, hs_s, rst_s, own_done;
    bif.BURST_ACK  = 1'b0;
    bif.BURST_DONE = 1'b0;
    now = 0; req_age = 0; cur_ack = 0; own_done = 0;
    forever begin
      @(negedge ACLK);
      req_s = bif.BURST_REQ;
      hs_s  = bif.BURST_REQ && bif.BURST_ACK;
      rst_s = !ARESETN;
      @(posedge ACLK);
      #2;
      now++;
      if (rst_s) begin
        due_q.delete();
        req_age  = 0;
        own_done = 0;
      end else begin
        if (own_done) void'(due_q.pop_front());
        if (hs_s) due_q.push_back(now - 1 + (done_rand ? int'($urandom_range(1, 8)) : done_delay));
        if (req_s && !hs_s) req_age++;
        else begin
          req_age = 0;
          cur_ack = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
        end
      end
      bif.BURST_ACK  = bif.BURST_REQ && (req_age >= cur_ack);
      own_done       = !rst_s && !hold_done && due_q.size() > 0 && due_q[0] <= now;
      bif.BURST_DONE = own_done || spur_done;
      if (fifo_rand)
        FIFO_CNT = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15))
                                               : 10'($urandom_range(16, 1023));
    end
  end

  // Transaction monitor and outstanding-count reference.
  always @(negedge ACLK) begin : monitor
    bit hs, dn;
    if (!ARESETN) begin
      outst_model = 0; req_prev_m = 0; hs_prev_m = 0; run_len = 0;
      fifo_prev = FIFO_CNT;
    end else begin
      hs = bif.BURST_REQ && bif.BURST_ACK;
      dn = bif.BURST_DONE;
      check("outst", longint'(dut.outst_reg), outst_model);
      if (hs_prev_m) check("req_low_after_ack", longint'(bif.BURST_REQ), 0);
      if (bif.BURST_REQ) begin
        n_req_cycles++;
        run_len++;
        if (!req_prev_m) check("req_needs_full_burst", longint'(fifo_prev >= BB), 1);
        else if (!hs_prev_m) check("addr_stable", bif.BURST_ADDR, addr_prev);
      end
      if (hs) begin
        check("outst_limit", longint'(outst_model < MO), 1);
        addr_log.push_back(bif.BURST_ADDR);
        req_len_log.push_back(run_len);
        dones_at_ack.push_back(n_dn);
        $display("burst addr=0x%08h len=%0d req_cycles=%0d", bif.BURST_ADDR, bif.BURST_LEN, run_len);
        run_len = 0;
      end
      if (hs && dn) n_sim++;
      if (dn && outst_model > 0) n_dn++;
      if (FRAME_DONE) begin
        n_done++;
        dones_at_end = n_dn;
        check("done_after_drain", outst_model, 0);
        $display("frame done after %0d bursts", addr_log.size());
      end
      if (FRAME_ABORT) begin
        n_abort++;
        check("abort_after_drain", outst_model, 0);
        $display("frame abort after %0d bursts", addr_log.size());
      end
      if (FIFO_CLR) n_clr++;
      if (hs && !dn) outst_model++;
      else if (!hs && dn && outst_model > 0) outst_model--;
      req_prev_m = bif.BURST_REQ;
      hs_prev_m  = hs;
      addr_prev  = bif.BURST_ADDR;
      fifo_prev  = FIFO_CNT;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [28:0]      cap_addr;
    int               ack_d;
    int               done_d;
    logic [5:0][31:0] exp;
  } frame_vec_t;

  frame_vec_t vec[4];

  initial begin : main
    logic [28:0] cap;
    logic [31:0] exp_a;

    vec[0].cap_addr = 29'h0100_0040; vec[0].ack_d = 0; vec[0].done_d = 3;
    vec[0].exp = {32'h0100_0280, 32'h0100_0200, 32'h0100_0180,
                  32'h0100_0100, 32'h0100_0080, 32'h0100_0000};
    vec[1].cap_addr = 29'h1FFF_FF80; vec[1].ack_d = 1; vec[1].done_d = 1;
    vec[1].exp = {32'h0000_0200, 32'h0000_0180, 32'h0000_0100,
                  32'h0000_0080, 32'h0000_0000, 32'h1FFF_FF80};
    vec[2].cap_addr = 29'h0000_007F; vec[2].ack_d = 2; vec[2].done_d = 5;
    vec[2].exp = {32'h0000_0280, 32'h0000_0200, 32'h0000_0180,
                  32'h0000_0100, 32'h0000_0080, 32'h0000_0000};
    vec[3].cap_addr = 29'h1234_5678; vec[3].ack_d = 0; vec[3].done_d = 7;
    vec[3].exp = {32'h1234_5880, 32'h1234_5800, 32'h1234_5780,
                  32'h1234_5700, 32'h1234_5680, 32'h1234_5600};

    ARESETN = 1'b0; CAP_ON = 1'b0; VSYNC = 1'b0; CAP_ADDR = '0; FIFO_CNT = '0;
    repeat (3) @(negedge ACLK);
    check("rst_burst_req", longint'(bif.BURST_REQ), 0);
    check("rst_burst_addr", bif.BURST_ADDR, 0);
    check("rst_burst_len", bif.BURST_LEN, BB - 1);
    check("rst_fifo_clr", longint'(FIFO_CLR), 0);
    check("rst_frame_done", longint'(FRAME_DONE), 0);
    check("rst_frame_abort", longint'(FRAME_ABORT), 0);
    check("rst_busy", longint'(BUSY), 0);
    #2 ARESETN = 1'b1;
    tick();
    tick();
    check("idle_busy", longint'(BUSY), 0);
    CAP_ON = 1'b1;
    tick();
    tick();
    check("armed_busy", longint'(BUSY), 1);

    // full frames from the vector table
    for (int v = 0; v < 4; v++) begin
      CAP_ADDR = vec[v].cap_addr; ack_delay = vec[v].ack_d; done_delay = vec[v].done_d;
      clear_log();
      FIFO_CNT = 10'd0;
      pulse_vsync();
      FIFO_CNT = 10'd16;
      wait_end("tbl", 400);
      check($sformatf("tbl%0d_nbursts", v), addr_log.size(), FB);
      for (int i = 0; i < FB; i++)
        check($sformatf("tbl%0d_addr%0d", v, i),
              (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, vec[v].exp[i]);
      check($sformatf("tbl%0d_done", v), n_done, 1);
      check($sformatf("tbl%0d_abort", v), n_abort, 0);
      check($sformatf("tbl%0d_clr", v), n_clr, 1);
      check($sformatf("tbl%0d_done_after_last", v), dones_at_end, FB);
    end

    // throttling on FIFO level and on outstanding bursts
    ack_delay = 0; done_delay = 3; CAP_ADDR = 29'h0100_0040;
    clear_log();
    FIFO_CNT = 10'd15;
    pulse_vsync();
    repeat (20) tick();
    check("thr_no_req_at_15", n_req_cycles, 0);
    hold_done = 1'b1;
    FIFO_CNT  = 10'd16;
    @(negedge ACLK);
    check("thr_req_not_same_cycle", longint'(bif.BURST_REQ), 0);
    @(negedge ACLK);
    check("thr_req_next_cycle", longint'(bif.BURST_REQ), 1);
    repeat (40) tick();
    check("thr_acks_at_limit", addr_log.size(), MO);
    check("thr_no_req_at_limit", longint'(bif.BURST_REQ), 0);
    hold_done = 1'b0;
    wait_end("thr", 200);
    check("thr_nbursts", addr_log.size(), FB);
    check("thr_fifth_after_done",
          longint'((dones_at_ack.size() > MO) ? (dones_at_ack[MO] > 0) : 1'b0), 1);
    check("thr_done", n_done, 1);

    // mid-frame VSYNC while a request waits for its ACK
    ack_delay = 4;
    clear_log();
    FIFO_CNT = 10'd0;
    pulse_vsync();
    FIFO_CNT = 10'd16;
    wait_req("abort", 50);
    VSYNC = 1'b1;
    tick();
    wait_end("abort", 100);
    check("abort_req_held", (req_len_log.size() > 0) ? req_len_log[0] : 0, 5);
    check("abort_nbursts", addr_log.size(), 1);
    check("abort_pulse", n_abort, 1);
    check("abort_no_done", n_done, 0);
    VSYNC = 1'b0;
    repeat (10) tick();
    check("abort_no_restart_clr", n_clr, 1);
    check("abort_no_restart_burst", addr_log.size(), 1);
    check("abort_waits_vs", longint'(BUSY), 1);
    ack_delay = 0;
    FIFO_CNT = 10'd0;
    pulse_vsync();
    check("abort_next_clr", n_clr, 2);
    FIFO_CNT = 10'd16;
    wait_end("abort_next", 200);
    check("abort_next_done", n_done, 1);
    check("abort_next_nbursts", addr_log.size(), FB + 1);
    check("abort_next_base", (addr_log.size() > 1) ? addr_log[1] : 32'hFFFF_FFFF, 32'h0100_0000);

    // CAP_ON dropped mid-frame
    clear_log();
    FIFO_CNT = 10'd0;
    pulse_vsync();
    FIFO_CNT = 10'd16;
    for (int i = 0; i < 60 && addr_log.size() < 2; i++) tick();
    CAP_ON = 1'b0;
    wait_end("capoff", 200);
    check("capoff_nbursts", addr_log.size(), FB);
    check("capoff_done", n_done, 1);
    repeat (3) tick();
    check("capoff_idle", longint'(BUSY), 0);
    pulse_vsync();
    repeat (3) tick();
    check("capoff_no_clr", n_clr, 1);
    check("capoff_no_burst", addr_log.size(), FB);

    // ACK and DONE in the same cycle, then a stray DONE
    CAP_ON = 1'b1; done_delay = 2;
    clear_log();
    FIFO_CNT = 10'd0;
    pulse_vsync();
    FIFO_CNT = 10'd16;
    wait_end("sim", 200);
    check("sim_overlap_seen", longint'(n_sim > 0), 1);
    check("sim_done", n_done, 1);
    repeat (3) tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (3) tick();
    check("spur_outst_zero", longint'(dut.outst_reg), 0);
    done_delay = 3;

    // reset while a request is pending
    ack_delay = 10;
    clear_log();
    FIFO_CNT = 10'd0;
    pulse_vsync();
    FIFO_CNT = 10'd16;
    wait_req("rst", 50);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_mid_req_drop", longint'(bif.BURST_REQ), 0);
    check("rst_mid_busy", longint'(BUSY), 0);
    check("rst_mid_addr", bif.BURST_ADDR, 0);
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    ack_delay = 0;
    tick();
    clear_log();
    repeat (10) tick();
    check("rst_rel_busy", longint'(BUSY), 1);
    check("rst_rel_no_req", n_req_cycles, 0);
    check("rst_rel_no_clr", n_clr, 0);
    FIFO_CNT = 10'd0;
    pulse_vsync();
    FIFO_CNT = 10'd16;
    wait_end("rst_rel", 200);
    check("rst_rel_done", n_done, 1);
    check("rst_rel_nbursts", addr_log.size(), FB);

    // random frames against the address/frame reference
    fifo_rand = 1'b1; ack_rand = 1'b1; done_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      cap = 29'($urandom);
      CAP_ADDR = cap;
      clear_log();
      pulse_vsync();
      wait_end("rnd", 1500);
      check($sformatf("rnd%0d_nbursts", f), addr_log.size(), FB);
      for (int i = 0; i < FB; i++) begin
        exp_a = {3'b000, 29'((cap & ~29'h7F) + 29'(i * BB * BYTES))};
        check($sformatf("rnd%0d_addr%0d", f, i),
              (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, exp_a);
      end
      check($sformatf("rnd%0d_done", f), n_done, 1);
      check($sformatf("rnd%0d_abort", f), n_abort, 0);
    end
    fifo_rand = 1'b0; ack_rand = 1'b0; done_rand = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
